// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_RD = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_GRANT_WR = 2'd3
    } arb_state_t;

    localparam int ARB_ADDR_W       = 25;
    localparam int ARB_DATA_W       = 16;
    localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/sdram_arb_starve_ctr.sv
// Counts consecutive read grants while a write is pending; saturates at
// STARVE_LIMIT and flags the writer as starved once the limit is reached.
module sdram_arb_starve_ctr
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic clk50,
    input  logic reset,
    input  logic i_rd_grant,
    input  logic i_wr_grant,
    input  logic i_wr_pending,
    output logic o_starved
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_count;

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_wr_pending || i_wr_grant) begin
            r_count <= '0;
        end else if (i_rd_grant && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_starved = (r_count == LIMIT);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM arbiter: playback reads have priority over loader writes.
// Define SDRAM_ARB_STARVE_GUARD_EN to bound consecutive reads while a write waits.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              wr_we,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_op_begun,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_address,
    output logic              rd_op_begun,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_op_begun,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              busy
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("sdram_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              w_starved;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_data_valid;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    logic w_grant_rd;
    logic w_grant_wr;

    assign w_grant_rd = (r_state == ST_IDLE) && (w_state_next == ST_GRANT_RD);
    assign w_grant_wr = (r_state == ST_IDLE) && (w_state_next == ST_GRANT_WR);

    sdram_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk50        (clk50),
        .reset        (reset),
        .i_rd_grant   (w_grant_rd),
        .i_wr_grant   (w_grant_wr),
        .i_wr_pending (wr_we),
        .o_starved    (w_starved)
    );
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every transaction returns through IDLE, which gives the one-cycle
    // mem_req-low turnaround between back-to-back accesses.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        rd_op_begun  = 1'b0;
        wr_op_begun  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rd_req && !w_starved) begin
                    w_state_next = ST_GRANT_RD;
                end else if (wr_we) begin
                    w_state_next = ST_GRANT_WR;
                end
            end
            ST_GRANT_RD: begin
                mem_req     = 1'b1;
                mem_address = rd_address;
                if (mem_op_begun) begin
                    rd_op_begun  = 1'b1;
                    w_state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rdata_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GRANT_WR: begin
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_address = wr_address;
                mem_wdata   = wr_data;
                if (mem_op_begun) begin
                    wr_op_begun  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Read data is captured only in RD_WAIT so late data after a reset is dropped.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            r_rd_data_valid <= (r_state == ST_RD_WAIT) && mem_rdata_valid;
            if ((r_state == ST_RD_WAIT) && mem_rdata_valid) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_data_valid;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed cases plus randomized
// traffic scored against a transaction-level priority/starvation model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int LIMIT  = 4;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk50 = 1'b0;
    logic              reset = 1'b1;
    logic              wr_we = 1'b0;
    logic [ADDR_W-1:0] wr_address = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_op_begun;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_address = '0;
    logic              rd_op_begun;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_op_begun = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rdata_valid = 1'b0;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int model_starve = 0;
    int wr_grants = 0;
    string grant_log;

    sdram_port_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W)
    ) dut (
        .clk50           (clk50),
        .reset           (reset),
        .wr_we           (wr_we),
        .wr_address      (wr_address),
        .wr_data         (wr_data),
        .wr_op_begun     (wr_op_begun),
        .rd_req          (rd_req),
        .rd_address      (rd_address),
        .rd_op_begun     (rd_op_begun),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_op_begun    (mem_op_begun),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .busy            (busy)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic raise_rd(input logic [ADDR_W-1:0] addr);
        rd_req     = 1'b1;
        rd_address = addr;
    endtask

    task automatic raise_wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_we      = 1'b1;
        wr_address = addr;
        wr_data    = data;
    endtask

    // Returns at the negedge of the first cycle with mem_req high, or after a bounded wait.
    task automatic wait_grant(output bit found);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk50);
            if (mem_req) begin
                found = 1'b1;
                break;
            end
        end
        check("grant_seen", 32'(found), 32'd1);
    endtask

    // One full transaction from an IDLE negedge with requests already raised.
    // The model picks the winner from the pending set and the starve history.
    task automatic do_txn(input int op_delay, input int rd_lat, input logic [DATA_W-1:0] rdata);
        bit                found;
        bit                exp_read;
        logic [ADDR_W-1:0] exp_addr;
        exp_read = rd_req && !(GUARD && (model_starve == LIMIT));
        if (exp_read) model_starve = wr_we ? ((model_starve < LIMIT) ? model_starve + 1 : LIMIT) : 0;
        else          model_starve = 0;
        exp_addr = exp_read ? rd_address : wr_address;
        grant_log = {grant_log, exp_read ? "R" : "W"};

        wait_grant(found);
        if (!found) return;
        check("grant_we",     32'(mem_we), 32'(!exp_read));
        check("grant_addr",   32'(mem_address), 32'(exp_addr));
        check("grant_wdata",  32'(mem_wdata), exp_read ? 32'd0 : 32'(wr_data));
        check("grant_acks",   {30'd0, rd_op_begun, wr_op_begun}, 32'd0);
        check("grant_busy",   32'(busy), 32'd1);
        check("grant_rdv",    32'(rd_data_valid), 32'd0);

        repeat (op_delay) begin
            @(negedge clk50);
            check("hold_req", {30'd0, mem_req, rd_op_begun | wr_op_begun}, 32'd2);
        end
        mem_op_begun = 1'b1;
        #1;
        check("ack_rd", 32'(rd_op_begun), 32'(exp_read));
        check("ack_wr", 32'(wr_op_begun), 32'(!exp_read));
        if (wr_op_begun) wr_grants++;
        @(posedge clk50);
        #1;
        mem_op_begun = 1'b0;
        if (exp_read) rd_req = 1'b0;
        else          wr_we  = 1'b0;

        @(negedge clk50);
        check("turnaround_req", 32'(mem_req), 32'd0);
        check("post_ack", {30'd0, rd_op_begun, wr_op_begun}, 32'd0);
        check("post_busy", 32'(busy), 32'(exp_read));
        if (!exp_read) return;

        repeat (rd_lat - 1) @(negedge clk50);
        mem_rdata       = rdata;
        mem_rdata_valid = 1'b1;
        #1;
        check("rdv_early", 32'(rd_data_valid), 32'd0);
        @(posedge clk50);
        #1;
        mem_rdata_valid = 1'b0;
        mem_rdata       = DATA_W'($urandom);
        @(negedge clk50);
        check("rdv_pulse", 32'(rd_data_valid), 32'd1);
        check("rd_data",   32'(rd_data), 32'(rdata));
        check("rd_idle",   32'(busy), 32'd0);
    endtask

    initial begin
        bit                found;
        logic [DATA_W-1:0] rdat;
        string             exp_log;

        // Reset state
        repeat (3) @(posedge clk50);
        #1;
        reset = 1'b0;
        @(negedge clk50);
        check("rst_mem", {28'd0, mem_req, mem_we, busy, rd_data_valid}, 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_acks", {30'd0, rd_op_begun, wr_op_begun}, 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);

        // Stray mem_op_begun in IDLE with no request
        mem_op_begun = 1'b1;
        repeat (2) begin
            #1;
            check("stray_ack", {29'd0, rd_op_begun, wr_op_begun, mem_req}, 32'd0);
            @(negedge clk50);
        end
        mem_op_begun = 1'b0;
        check("stray_busy", 32'(busy), 32'd0);

        // Single write, accepted on the second grant cycle
        raise_wr(25'h000010, 16'hA55A);
        do_txn(1, 1, '0);

        // Single read, data valid three cycles after acceptance
        raise_rd(25'h0800000);
        do_txn(0, 3, 16'h1234);

        // Both requesters held continuously for ten grants
        grant_log = "";
        for (int i = 0; i < 10; i++) begin
            if (!rd_req) raise_rd(ADDR_W'($urandom));
            if (!wr_we)  raise_wr(ADDR_W'($urandom), DATA_W'($urandom));
            do_txn(0, 1, DATA_W'($urandom));
        end
        exp_log = GUARD ? "RRRRWRRRRW" : "RRRRRRRRRR";
        tests++;
        assert (grant_log == exp_log)
        else begin
            fails++;
            $error("FAIL contention_order: observed %s expected %s", grant_log, exp_log);
        end

        // Twenty more contended grants: the writer wins only with the guard
        wr_grants = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rd_req) raise_rd(ADDR_W'($urandom));
            if (!wr_we)  raise_wr(ADDR_W'($urandom), DATA_W'($urandom));
            do_txn(0, 1, DATA_W'($urandom));
        end
        check("contention_wr_count", 32'(wr_grants), GUARD ? 32'd4 : 32'd0);
        if (wr_we) do_txn(0, 1, '0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            if (!wr_we && ($urandom_range(1) == 1)) raise_wr(ADDR_W'($urandom), DATA_W'($urandom));
            if (!rd_req && ($urandom_range(1) == 1)) raise_rd(ADDR_W'($urandom));
            if (!wr_we && !rd_req) raise_rd(ADDR_W'($urandom));
            do_txn(int'($urandom_range(2)), int'($urandom_range(4, 1)), DATA_W'($urandom));
        end
        for (int i = 0; i < 2 && (rd_req || wr_we); i++) do_txn(0, 1, DATA_W'($urandom));

        // Reset while in RD_WAIT, then late read data
        raise_rd(25'h0000ABC);
        wait_grant(found);
        mem_op_begun = 1'b1;
        @(posedge clk50);
        #1;
        mem_op_begun = 1'b0;
        rd_req = 1'b0;
        @(negedge clk50);
        check("rdwait_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk50);
        #1;
        reset = 1'b0;
        model_starve = 0;
        rdat = 16'hBEEF;
        mem_rdata = rdat;
        mem_rdata_valid = 1'b1;
        @(negedge clk50);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk50);
        #1;
        mem_rdata_valid = 1'b0;
        @(negedge clk50);
        check("abort_rdv", 32'(rd_data_valid), 32'd0);
        check("abort_rdata", 32'(rd_data), 32'd0);
        check("abort_state", {30'd0, busy, mem_req}, 32'd0);

        // Arbiter still works after the aborted access
        raise_wr(25'h1FFFFFF, 16'hFFFF);
        do_txn(2, 1, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive read grants while a write is pending.
REQ-002 SHALL have parameter ADDR_W, default 25, meaning word-address width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning data-word width.
REQ-004 SHALL use one clock and a synchronous active-high reset: clk50 in 1 system clock; reset in 1 synchronous, active-high.
REQ-005 SHALL have port wr_we in 1, write request from the SD-card loader, held until acknowledged.
REQ-006 SHALL have port wr_address in ADDR_W, write word address.
REQ-007 SHALL have port wr_data in DATA_W, write data.
REQ-008 SHALL have port wr_op_begun out 1, one-cycle write acknowledge.
REQ-009 SHALL have port rd_req in 1, playback read request, held until acknowledged.
REQ-010 SHALL have port rd_address in ADDR_W, read word address.
REQ-011 SHALL have port rd_op_begun out 1, one-cycle read acknowledge.
REQ-012 SHALL have port rd_data out DATA_W, registered read data.
REQ-013 SHALL have port rd_data_valid out 1, one-cycle read-data strobe.
REQ-014 SHALL have ports mem_req out 1, mem_we out 1, mem_address out ADDR_W and mem_wdata out DATA_W, the memory command.
REQ-015 SHALL have ports mem_op_begun in 1 (command accepted), mem_rdata in DATA_W and mem_rdata_valid in 1.
REQ-016 SHALL have port busy out 1, high when not in IDLE.

Function
REQ-017 SHALL implement states IDLE, GRANT_RD, RD_WAIT and GRANT_WR.
REQ-018 In IDLE, SHALL go to GRANT_RD if rd_req is high and the writer is not starved, else to GRANT_WR if wr_we is high, else stay in IDLE.
REQ-019 When both requests are high in the same IDLE cycle, SHALL grant read unless the starve count equals STARVE_LIMIT.
REQ-020 In GRANT_RD, SHALL drive mem_req=1, mem_we=0 and mem_address=rd_address.
REQ-021 In GRANT_RD, SHALL assert rd_op_begun combinationally in the cycle mem_op_begun=1, then go to RD_WAIT.
REQ-022 In RD_WAIT, SHALL drive mem_req=0, register mem_rdata into rd_data on mem_rdata_valid, pulse rd_data_valid the following cycle, and return to IDLE.
REQ-023 In GRANT_WR, SHALL drive mem_req=1, mem_we=1, mem_address=wr_address and mem_wdata=wr_data.
REQ-024 In GRANT_WR, SHALL assert wr_op_begun combinationally in the cycle mem_op_begun=1, then return to IDLE.
REQ-025 SHALL hold mem_req low for at least one IDLE cycle between any two transactions (turnaround).
REQ-026 SHALL never assert an acknowledge to the non-granted requester, and never assert both acknowledges in one cycle.
REQ-027 SHALL ignore mem_op_begun outside GRANT_RD/GRANT_WR and mem_rdata_valid outside RD_WAIT.
REQ-028 SHALL sample request address/data live each cycle of the grant; requesters SHALL keep them stable until acknowledged.
REQ-029 Starve counter: SHALL increment on each read grant while wr_we=1, saturate at STARVE_LIMIT, and clear on a write grant or when wr_we=0.

Reset
REQ-030 On reset, SHALL enter IDLE with mem_req=0, mem_we=0, mem_address=0, mem_wdata=0, both acknowledges 0, rd_data=0, rd_data_valid=0, busy=0 and starve count 0.
REQ-031 On reset mid-transaction, SHALL abandon it, with no acknowledge and no rd_data_valid for the aborted access, including late mem_rdata_valid.

Configuration
REQ-032 With macro SDRAM_ARB_STARVE_GUARD_EN defined, SHALL include the starve counter and REQ-019/REQ-029 behaviour.
REQ-033 Without SDRAM_ARB_STARVE_GUARD_EN, SHALL use strict read priority with no counter logic and STARVE_LIMIT unused.

Structure
REQ-034 Package sdram_arb_pkg SHALL hold the state enum typedef, default ADDR_W/DATA_W constants and the STARVE_LIMIT default.
REQ-035 The starve counter SHALL be sub-module sdram_arb_starve_ctr, instantiated only under SDRAM_ARB_STARVE_GUARD_EN.

Verification
REQ-036 Single write: wr_we=1, wr_address=0x000010, wr_data=0xA55A, mem_op_begun on the 2nd grant cycle -> mem_we=1 with those values; wr_op_begun one cycle; return to IDLE.
REQ-037 Single read: rd_req, rd_address=0x0800000, mem_rdata=0x1234 valid 3 cycles after acceptance -> rd_op_begun one pulse; rd_data=0x1234 with rd_data_valid one cycle later.
REQ-038 Contention, guard on, STARVE_LIMIT=4: both requests held continuously -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-039 Contention, guard off: both requests held for 20 transactions -> zero wr_op_begun pulses.
REQ-040 Reset in RD_WAIT, then mem_rdata_valid=1 next cycle -> rd_data_valid stays 0, rd_data=0, state IDLE.
REQ-041 Stray mem_op_begun=1 in IDLE with no request -> no acknowledge pulses and mem_req stays 0.
